// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, word fetch and 2-entry prefetch queue feeding decode; flushes on redirect.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_bubbles counters.
module fetch_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              id_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);
    logic [ADDR_W-1:0] pc, req_pc, tgt;
    logic [ADDR_W-1:0] q_pc [2];
    logic [DATA_W-1:0] q_instr [2];
    logic [1:0] count, occ;
    logic inflight, head, pop, push;

    assign tgt = br_target & ~ADDR_W'(3);
    assign if_valid = count != 2'd0;
    assign if_instr = q_instr[head];
    assign if_pc = q_pc[head];
    assign pop = if_valid & ~id_stall;
    // A redirect discards the word returning this cycle
    assign push = inflight & ~br_taken;
    assign occ = count + {1'b0, inflight} - {1'b0, pop};
    assign imem_req = rst & (br_taken | (occ < 2'd2));
    assign imem_addr = (rst & br_taken) ? tgt : pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
            req_pc <= RESET_PC;
            inflight <= 1'b0;
            count <= 2'd0;
            head <= 1'b0;
            q_pc[0] <= RESET_PC;
            q_pc[1] <= RESET_PC;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
        end else begin
            if (imem_req) begin
                pc <= imem_addr + ADDR_W'(4);
                req_pc <= imem_addr;
            end
            inflight <= imem_req;
            if (push) begin
                q_instr[head ^ count[0]] <= imem_rdata;
                q_pc[head ^ count[0]] <= req_pc;
            end
            count <= br_taken ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
            if (pop) head <= ~head;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            if (!if_valid) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif
endmodule
